// File: rtl/gelato_ifetch_if.sv
// Scheduler-to-ifetch PC handoff: scheduler offers a PC, ifetch answers with a caught pulse.
interface gelato_fetchskd_ifetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WARP_W     = 5,
  parameter int unsigned SPLIT_W    = 4
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic [WARP_W-1:0]     warp_num;
  logic [SPLIT_W-1:0]    split_table_num;
  logic                  caught;

  modport master (output valid, pc, warp_num, split_table_num, input caught);
  modport slave  (input valid, pc, warp_num, split_table_num, output caught);
endinterface

// File: rtl/gelato_ifetch.sv
// Gelato instruction fetch: catch one warp PC, read the icache, hand the word to the decoder.
module gelato_ifetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned WARP_W     = 5,
  parameter int unsigned SPLIT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  gelato_fetchskd_ifetch_if.slave inst_pc,
  output logic                  icache_req_valid,
  output logic [ADDR_WIDTH-1:0] icache_req_addr,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  input  logic [INST_WIDTH-1:0] icache_resp_data,
  input  logic                  flush_valid,
  input  logic [WARP_W-1:0]     flush_warp_num,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INST_WIDTH-1:0] dec_inst,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [WARP_W-1:0]     dec_warp_num,
  output logic [SPLIT_W-1:0]    dec_split_table_num,
  output logic                  dec_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic                  caught_q, caught_d;
  logic                  killed_q, killed_d;
  logic                  fault_q,  fault_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [INST_WIDTH-1:0] inst_q,   inst_d;
  logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
  logic [WARP_W-1:0]     warp_q,   warp_d;
  logic [SPLIT_W-1:0]    split_q,  split_d;
  logic                  flush_hit;

  assign flush_hit = flush_valid && (flush_warp_num == warp_q);

  // Next-state and payload logic; everything holds while rdy is low.
  always_comb begin
    state_d  = state_q;
    caught_d = caught_q;
    killed_d = killed_q;
    fault_d  = fault_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    warp_d   = warp_q;
    split_d  = split_q;
    if (rdy) begin
      caught_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inst_pc.valid && !caught_q) begin
            pc_d     = inst_pc.pc;
            warp_d   = inst_pc.warp_num;
            split_d  = inst_pc.split_table_num;
            addr_d   = {inst_pc.pc[ADDR_WIDTH-1:2], 2'b00};
            caught_d = 1'b1;
            killed_d = 1'b0;
            if (inst_pc.pc[1:0] != 2'b00) begin
              fault_d = 1'b1;
              inst_d  = '0;
              state_d = S_OUT;
            end else begin
              fault_d = 1'b0;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush_hit) begin
            state_d = S_IDLE;
          end else if (icache_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (icache_resp_valid) begin
            // A flush landing with the response still kills it.
            if (killed_q || flush_hit) begin
              state_d = S_IDLE;
            end else begin
              inst_d  = icache_resp_data;
              state_d = S_OUT;
            end
          end else if (flush_hit) begin
            killed_d = 1'b1;
          end
        end
        S_OUT: begin
          if (flush_hit || dec_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      caught_q <= 1'b0;
      killed_q <= 1'b0;
      fault_q  <= 1'b0;
      addr_q   <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
      warp_q   <= '0;
      split_q  <= '0;
    end else begin
      state_q  <= state_d;
      caught_q <= caught_d;
      killed_q <= killed_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      warp_q   <= warp_d;
      split_q  <= split_d;
    end
  end

  assign inst_pc.caught      = caught_q;
  assign icache_req_valid    = (state_q == S_REQ);
  assign icache_req_addr     = addr_q;
  assign dec_valid           = (state_q == S_OUT);
  assign dec_inst            = inst_q;
  assign dec_pc              = pc_q;
  assign dec_warp_num        = warp_q;
  assign dec_split_table_num = split_q;
  assign dec_fault           = fault_q;

endmodule
